// File: rtl/alu_uart_intf_pkg.sv
// Shared constants for the ALU/UART byte sequencer: FSM encoding,
// default widths and the ALU opcode map.
package alu_uart_intf_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int OP_WIDTH_DEF     = 6;
  localparam int PARITY_WIDTH_DEF = 1;

  // Sequencer states, 3-bit encoding
  localparam logic [2:0] WAIT_OP1    = 3'd0;
  localparam logic [2:0] WAIT_OP2    = 3'd1;
  localparam logic [2:0] WAIT_OPCODE = 3'd2;
  localparam logic [2:0] EXEC        = 3'd3;
  localparam logic [2:0] WAIT_TX     = 3'd4;

  // ALU opcodes (low OP_WIDTH bits of the received opcode byte)
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_uart_intf_if.sv
// Bundle of UART RX/TX and ALU signals seen by the sequencer.
// slave = sequencer side, master = surrounding top level / UART / ALU.
interface alu_uart_intf_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OP_WIDTH     = 6,
  parameter int PARITY_WIDTH = 1
) ();
  logic                    i_rx_done;
  logic [DATA_WIDTH-1:0]   i_rx_data;
  logic [PARITY_WIDTH-1:0] i_rx_parity;
  logic                    i_tx_done;
  logic [DATA_WIDTH-1:0]   i_alu_result;
  logic [DATA_WIDTH-1:0]   o_op1;
  logic [DATA_WIDTH-1:0]   o_op2;
  logic [OP_WIDTH-1:0]     o_opcode;
  logic                    o_tx_signal;
  logic [DATA_WIDTH-1:0]   o_tx_result;
  logic [PARITY_WIDTH-1:0] o_tx_parity;
  logic                    o_busy;
  logic                    o_parity_err;

  modport slave (
    input  i_rx_done, i_rx_data, i_rx_parity, i_tx_done, i_alu_result,
    output o_op1, o_op2, o_opcode, o_tx_signal, o_tx_result, o_tx_parity,
           o_busy, o_parity_err
  );

  modport master (
    output i_rx_done, i_rx_data, i_rx_parity, i_tx_done, i_alu_result,
    input  o_op1, o_op2, o_opcode, o_tx_signal, o_tx_result, o_tx_parity,
           o_busy, o_parity_err
  );
endinterface

// File: rtl/alu_uart_intf_edge_detect.sv
// 1-bit rising-edge detector. A level held high yields a single pulse.
module edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);
  logic r_q;

  // Remember last-cycle value of the input
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_q <= 1'b0;
    else         r_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_q;
endmodule

// File: rtl/alu_uart_intf.sv
// Byte sequencer between UART and combinational ALU: collects op1, op2,
// opcode, launches the ALU result on TX, waits for TX completion.
// Optional macro PARITY_CHECK_EN: reject odd-parity bytes, restart the
// sequence and set a sticky o_parity_err.
module alu_uart_intf
  import alu_uart_intf_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OP_WIDTH     = OP_WIDTH_DEF,
  parameter int PARITY_WIDTH = PARITY_WIDTH_DEF
) (
  input  logic           i_clock,
  input  logic           i_reset,
  alu_uart_intf_if.slave bus
);
  logic [2:0]              r_state;
  logic [DATA_WIDTH-1:0]   r_op1, r_op2, r_tx_result;
  logic [OP_WIDTH-1:0]     r_opcode;
  logic                    r_tx_signal, r_busy, r_parity_err;
  logic [PARITY_WIDTH-1:0] r_tx_parity;
  logic                    w_rx_ev, w_tx_ev, w_rx_bad, w_collecting, w_rx_reject;

  edge_detect u_rx_edge (
    .i_clock (i_clock), .i_reset (i_reset),
    .i_sig   (bus.i_rx_done), .o_rise (w_rx_ev)
  );

  edge_detect u_tx_edge (
    .i_clock (i_clock), .i_reset (i_reset),
    .i_sig   (bus.i_tx_done), .o_rise (w_tx_ev)
  );

  // Only the three collecting states care about incoming bytes
  assign w_collecting = (r_state == WAIT_OP1) || (r_state == WAIT_OP2) ||
                        (r_state == WAIT_OPCODE);

`ifdef PARITY_CHECK_EN
  // Even parity over data plus parity field must come out zero
  assign w_rx_bad = (^bus.i_rx_data) ^ (^bus.i_rx_parity);
`else
  logic w_unused_parity;
  assign w_unused_parity = ^bus.i_rx_parity;
  assign w_rx_bad        = 1'b0;
`endif

  assign w_rx_reject = w_rx_ev & w_rx_bad & w_collecting;

  // Sequencer FSM plus operand/result registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= WAIT_OP1;
      r_op1       <= '0;
      r_op2       <= '0;
      r_opcode    <= '0;
      r_tx_result <= '0;
      r_tx_parity <= '0;
      r_tx_signal <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tx_signal <= 1'b0;
      if (w_rx_reject) begin
        r_state <= WAIT_OP1;
      end else begin
        case (r_state)
          WAIT_OP1: if (w_rx_ev) begin
            r_op1   <= bus.i_rx_data;
            r_state <= WAIT_OP2;
          end
          WAIT_OP2: if (w_rx_ev) begin
            r_op2   <= bus.i_rx_data;
            r_state <= WAIT_OPCODE;
          end
          WAIT_OPCODE: if (w_rx_ev) begin
            r_opcode <= bus.i_rx_data[OP_WIDTH-1:0];
            r_busy   <= 1'b1;
            r_state  <= EXEC;
          end
          EXEC: begin
            r_tx_result <= bus.i_alu_result;
            r_tx_parity <= PARITY_WIDTH'(^bus.i_alu_result);
            r_tx_signal <= 1'b1;
            r_state     <= WAIT_TX;
          end
          WAIT_TX: if (w_tx_ev) begin
            // a byte arriving on this same edge is dropped
            r_busy  <= 1'b0;
            r_state <= WAIT_OP1;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= WAIT_OP1;
          end
        endcase
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Sticky parity error, cleared only by reset
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          r_parity_err <= 1'b0;
    else if (w_rx_reject) r_parity_err <= 1'b1;
  end
`else
  assign r_parity_err = 1'b0;
`endif

  assign bus.o_op1        = r_op1;
  assign bus.o_op2        = r_op2;
  assign bus.o_opcode     = r_opcode;
  assign bus.o_tx_signal  = r_tx_signal;
  assign bus.o_tx_result  = r_tx_result;
  assign bus.o_tx_parity  = r_tx_parity;
  assign bus.o_busy       = r_busy;
  assign bus.o_parity_err = r_parity_err;
endmodule

// File: tb/tb_alu_uart_intf.sv
// Directed bench for alu_uart_intf with a behavioural ALU model.
module tb_alu_uart_intf;
  import alu_uart_intf_pkg::*;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_uart_intf_if #(.DATA_WIDTH(8), .OP_WIDTH(6), .PARITY_WIDTH(1)) bus ();

  alu_uart_intf dut (.i_clock(i_clock), .i_reset(i_reset), .bus(bus));

  always #5 i_clock = ~i_clock;

  // Combinational ALU model driven by the DUT operand outputs
  always_comb begin
    case (bus.o_opcode)
      OP_ADD:  bus.i_alu_result = bus.o_op1 + bus.o_op2;
      OP_SUB:  bus.i_alu_result = bus.o_op1 - bus.o_op2;
      OP_AND:  bus.i_alu_result = bus.o_op1 & bus.o_op2;
      OP_OR:   bus.i_alu_result = bus.o_op1 | bus.o_op2;
      OP_XOR:  bus.i_alu_result = bus.o_op1 ^ bus.o_op2;
      OP_NOR:  bus.i_alu_result = ~(bus.o_op1 | bus.o_op2);
      OP_SRA:  bus.i_alu_result = $signed(bus.o_op1) >>> bus.o_op2;
      OP_SRL:  bus.i_alu_result = bus.o_op1 >> bus.o_op2;
      default: bus.i_alu_result = 8'h00;
    endcase
  end

  task automatic send_byte(input logic [7:0] d, input logic p);
    @(negedge i_clock);
    bus.i_rx_done = 1'b1; bus.i_rx_data = d; bus.i_rx_parity = p;
    @(negedge i_clock);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_byte(d, ^d);
  endtask

  task automatic tx_done_pulse();
    @(negedge i_clock); bus.i_tx_done = 1'b1;
    @(negedge i_clock); bus.i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [43:0] got;
    bus.i_rx_done = 0; bus.i_rx_data = 0; bus.i_rx_parity = 0; bus.i_tx_done = 0;
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    got = {bus.o_op1, bus.o_op2, bus.o_opcode, bus.o_tx_result,
           bus.o_tx_parity, bus.o_tx_signal, bus.o_busy, bus.o_parity_err, 10'd0};
    n_cmp++;
    if (got !== 44'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", got);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_add();
    send_good(8'h05); send_good(8'h03); send_good(8'h20);
    n_cmp++;
    if ({bus.o_op1, bus.o_op2} !== 16'h0503) begin
      n_err++; $display("FAIL add_operands got=%h want=0503", {bus.o_op1, bus.o_op2});
    end
    n_cmp++;
    if (bus.o_opcode !== 6'h20) begin
      n_err++; $display("FAIL add_opcode got=%h want=20", bus.o_opcode);
    end
    n_cmp++;
    if (bus.o_busy !== 1'b1 || bus.o_tx_signal !== 1'b0) begin
      n_err++; $display("FAIL add_exec got busy=%b tx=%b want busy=1 tx=0", bus.o_busy, bus.o_tx_signal);
    end
    @(negedge i_clock);
    n_cmp++;
    if ({bus.o_tx_signal, bus.o_tx_result, bus.o_tx_parity} !== {1'b1, 8'h08, 1'b1}) begin
      n_err++; $display("FAIL add_tx got sig=%b res=%h par=%b want 1/08/1",
                        bus.o_tx_signal, bus.o_tx_result, bus.o_tx_parity);
    end
    @(negedge i_clock);
    n_cmp++;
    if (bus.o_tx_signal !== 1'b0) begin
      n_err++; $display("FAIL add_strobe_width got=%b want=0", bus.o_tx_signal);
    end
    // byte and tx_done on the same edge: back to WAIT_OP1, byte dropped
    bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h66; bus.i_rx_parity = 1'b0; bus.i_tx_done = 1'b1;
    @(negedge i_clock);
    bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_op1 !== 8'h05) begin
      n_err++; $display("FAIL simul_rx_tx got busy=%b op1=%h want 0/05", bus.o_busy, bus.o_op1);
    end
  endtask

  task automatic test_sra_drop();
    send_good(8'h80); send_good(8'h03); send_good(8'h03);
    n_cmp++;
    if (bus.o_op1 !== 8'h80) begin
      n_err++; $display("FAIL sra_op1 got=%h want=80", bus.o_op1);
    end
    @(negedge i_clock);
    n_cmp++;
    if ({bus.o_tx_signal, bus.o_tx_result, bus.o_tx_parity} !== {1'b1, 8'hF0, 1'b0}) begin
      n_err++; $display("FAIL sra_tx got sig=%b res=%h par=%b want 1/f0/0",
                        bus.o_tx_signal, bus.o_tx_result, bus.o_tx_parity);
    end
    send_good(8'h55);
    n_cmp++;
    if (bus.o_op1 !== 8'h80 || bus.o_busy !== 1'b1) begin
      n_err++; $display("FAIL wait_tx_drop got op1=%h busy=%b want 80/1", bus.o_op1, bus.o_busy);
    end
    tx_done_pulse();
    send_good(8'h77);
    n_cmp++;
    if (bus.o_op1 !== 8'h77) begin
      n_err++; $display("FAIL after_tx_op1 got=%h want=77", bus.o_op1);
    end
    send_good(8'h01); send_good(8'h20);
    repeat (2) @(negedge i_clock);
    n_cmp++;
    if ({bus.o_tx_result, bus.o_tx_parity} !== {8'h78, 1'b0}) begin
      n_err++; $display("FAIL add2_tx got res=%h par=%b want 78/0", bus.o_tx_result, bus.o_tx_parity);
    end
    tx_done_pulse();
  endtask

  task automatic test_level_hold();
    @(negedge i_clock);
    bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h11; bus.i_rx_parity = 1'b0;
    repeat (5) @(negedge i_clock);
    bus.i_rx_done = 1'b0;
    n_cmp++;
    if ({bus.o_op1, bus.o_op2, bus.o_busy} !== {8'h11, 8'h01, 1'b0}) begin
      n_err++; $display("FAIL level_hold got op1=%h op2=%h busy=%b want 11/01/0",
                        bus.o_op1, bus.o_op2, bus.o_busy);
    end
    send_good(8'h22);
    n_cmp++;
    if (bus.o_op2 !== 8'h22 || bus.o_busy !== 1'b0) begin
      n_err++; $display("FAIL level_next_op2 got op2=%h busy=%b want 22/0", bus.o_op2, bus.o_busy);
    end
    send_good(8'hE4);
    n_cmp++;
    if (bus.o_opcode !== 6'h24) begin
      n_err++; $display("FAIL opcode_trunc got=%h want=24", bus.o_opcode);
    end
    repeat (2) @(negedge i_clock);
    n_cmp++;
    if ({bus.o_tx_result, bus.o_tx_parity} !== {8'h00, 1'b0}) begin
      n_err++; $display("FAIL and_tx got res=%h par=%b want 00/0", bus.o_tx_result, bus.o_tx_parity);
    end
    tx_done_pulse();
  endtask

  task automatic test_reset_mid();
    logic [43:0] got;
    send_good(8'h05); send_good(8'h03);
    #2 i_reset = 1'b1;
    #1;
    got = {bus.o_op1, bus.o_op2, bus.o_opcode, bus.o_tx_result,
           bus.o_tx_parity, bus.o_tx_signal, bus.o_busy, bus.o_parity_err, 10'd0};
    n_cmp++;
    if (got !== 44'd0) begin
      n_err++; $display("FAIL reset_mid got=%h want=0", got);
    end
    @(negedge i_clock); i_reset = 1'b0;
    send_good(8'h01); send_good(8'h02); send_good(8'h20);
    repeat (2) @(negedge i_clock);
    n_cmp++;
    if ({bus.o_tx_result, bus.o_tx_parity} !== {8'h03, 1'b0}) begin
      n_err++; $display("FAIL post_reset_tx got res=%h par=%b want 03/0", bus.o_tx_result, bus.o_tx_parity);
    end
    tx_done_pulse();
  endtask

  task automatic test_parity();
    send_byte(8'h03, 1'b1);
`ifdef PARITY_CHECK_EN
    n_cmp++;
    if (bus.o_parity_err !== 1'b1 || bus.o_op1 !== 8'h01) begin
      n_err++; $display("FAIL parity_reject got err=%b op1=%h want 1/01", bus.o_parity_err, bus.o_op1);
    end
    send_good(8'h09);
    n_cmp++;
    if (bus.o_op1 !== 8'h09 || bus.o_parity_err !== 1'b1) begin
      n_err++; $display("FAIL parity_restart got op1=%h err=%b want 09/1", bus.o_op1, bus.o_parity_err);
    end
`else
    n_cmp++;
    if (bus.o_parity_err !== 1'b0 || bus.o_op1 !== 8'h03) begin
      n_err++; $display("FAIL parity_ignored got err=%b op1=%h want 0/03", bus.o_parity_err, bus.o_op1);
    end
    send_good(8'h09);
    n_cmp++;
    if (bus.o_op2 !== 8'h09) begin
      n_err++; $display("FAIL parity_next_op2 got=%h want=09", bus.o_op2);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sra_drop();
    test_level_hold();
    test_reset_mid();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
